colision_puntaje: RTL and testbench

- Downstream consumer of the obstacle generator's `display_obs` / `tipo_obs` outputs.
- Tracks which obstacle type sits in each of the three 7-seg digits and judges the hero's action when an obstacle reaches digit 0.
- Keeps lives and a BCD score.
- Emits one-cycle `gano` / `perdio` pulses that the top-level state machine uses to leave GAME for WL.

---
 rtl/colision_puntaje_pkg.sv | 31 +++
 rtl/colision_puntaje_if.sv | 24 ++
 rtl/colision_puntaje_contador_bcd2.sv | 41 ++++
 rtl/colision_puntaje.sv | 188 ++++++++++++++++++
 tb/tb_colision_puntaje.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/colision_puntaje_pkg.sv
// Shared definitions for the hero game blocks: top-level state codes,
// hero action codes, default game constants and the FSM state type.
package heroe_pkg;

  localparam logic [2:0] OFF  = 3'd0;
  localparam logic [2:0] WLCM = 3'd1;
  localparam logic [2:0] CH   = 3'd2;
  localparam logic [2:0] GAME = 3'd3;
  localparam logic [2:0] WL   = 3'd4;
  localparam logic [2:0] PA   = 3'd5;

  localparam logic [1:0] ACC_SUELO  = 2'b00;
  localparam logic [1:0] ACC_SALTO  = 2'b01;
  localparam logic [1:0] ACC_AGACHE = 2'b10;

  localparam logic [1:0] VIDAS_INI_DEF = 2'd3;
  localparam logic [7:0] META_BCD_DEF  = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ESPERA,
    ST_VENTANA,
    ST_PAUSA
  } fsm_t;

  // Type 0 (ground obstacle) must be jumped, type 1 (overhead) must be ducked.
  function automatic logic accion_ok(input logic tipo, input logic [1:0] acc);
    return tipo ? (acc == ACC_AGACHE) : (acc == ACC_SALTO);
  endfunction

endpackage

// File: rtl/colision_puntaje_if.sv
// Signal bundle between the game top level / obstacle generator and the
// collision-and-score judge.
interface colision_puntaje_if;
  logic [2:0]  presente;
  logic [20:0] display_obs;
  logic [3:0]  tipo_obs;
  logic [1:0]  accion;
  logic        choque;
  logic        esquivado;
  logic        gano;
  logic        perdio;
  logic [1:0]  vidas;
  logic [7:0]  puntaje;

  modport slave (
    input  presente, display_obs, tipo_obs, accion,
    output choque, esquivado, gano, perdio, vidas, puntaje
  );

  modport master (
    output presente, display_obs, tipo_obs, accion,
    input  choque, esquivado, gano, perdio, vidas, puntaje
  );
endinterface

// File: rtl/colision_puntaje_contador_bcd2.sv
// Two-digit BCD counter, saturating at 99, with synchronous clear (priority)
// and increment; also exposes the value an increment would produce.
module contador_bcd2
  import heroe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [7:0] o_valor,
  output logic [7:0] o_siguiente
);

  logic [7:0] r_valor;
  logic [7:0] w_sig;

  always_comb begin
    w_sig = r_valor;
    if (r_valor == 8'h99) begin
      w_sig = 8'h99;
    end else if (r_valor[3:0] >= 4'd9) begin
      w_sig = {r_valor[7:4] + 4'd1, 4'd0};
    end else begin
      w_sig = {r_valor[7:4], r_valor[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valor <= 8'h00;
    end else if (i_clr) begin
      r_valor <= 8'h00;
    end else if (i_inc) begin
      r_valor <= w_sig;
    end
  end

  assign o_valor     = r_valor;
  assign o_siguiente = w_sig;

endmodule

// File: rtl/colision_puntaje.sv
// Collision judge: shadows the obstacle type per display digit, opens a timed
// window when an obstacle reaches digit 0 and scores the hero's reaction.
module colision_puntaje
  import heroe_pkg::*;
#(
  parameter logic [23:0] VENTANA   = 24'd6750000,
  parameter logic [1:0]  VIDAS_INI = VIDAS_INI_DEF,
  parameter logic [7:0]  META_BCD  = META_BCD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  colision_puntaje_if.slave  bus
);

  logic [20:0] r_d_q;
  logic [20:0] r_d_qq;
  logic [3:0]  r_tp_q;
  logic [2:0]  r_pr_q;

  logic        r_o2, r_o1, r_o0;
  logic        r_t2, r_t1, r_t0;

  fsm_t        r_estado, w_estado_next;
  fsm_t        r_guardado, w_guardado_next;
  logic [23:0] r_cnt, w_cnt_next;

  logic        r_choque, r_esq, r_gano, r_perdio;
  logic [1:0]  r_vidas;

  logic        w_en_juego, w_pausa, w_ev, w_llegada, w_ok;
  logic        w_choque, w_esq, w_recarga, w_limpiar;
  logic [1:0]  w_vidas_dec;
  logic [7:0]  w_puntaje, w_puntaje_sig;
  logic        w_unused_tp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_q  <= '0;
      r_d_qq <= '0;
      r_tp_q <= '0;
      r_pr_q <= OFF;
    end else begin
      r_d_q  <= bus.display_obs;
      r_d_qq <= r_d_q;
      r_tp_q <= bus.tipo_obs;
      r_pr_q <= bus.presente;
    end
  end

  assign w_en_juego  = (r_pr_q == GAME);
  assign w_pausa     = (r_pr_q == PA);
  assign w_ev        = w_en_juego && (r_d_q != r_d_qq);
  assign w_llegada   = w_ev && r_o1;
  assign w_ok        = accion_ok(r_t0, bus.accion);
  assign w_unused_tp = ^r_tp_q[3:1];

  // The generator already shows the next type by the time an obstacle lands,
  // so each digit carries the type it was spawned with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_o2, r_o1, r_o0} <= 3'b000;
      {r_t2, r_t1, r_t0} <= 3'b000;
    end else if (w_limpiar) begin
      {r_o2, r_o1, r_o0} <= 3'b000;
      {r_t2, r_t1, r_t0} <= 3'b000;
    end else if (w_ev) begin
      r_o2 <= (r_d_q[20:14] != 7'd0);
      r_t2 <= r_tp_q[0];
      r_o1 <= r_o2;
      r_t1 <= r_t2;
      r_o0 <= r_o1;
      r_t0 <= r_t1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= ST_IDLE;
      r_guardado <= ST_ESPERA;
      r_cnt      <= '0;
    end else begin
      r_estado   <= w_estado_next;
      r_guardado <= w_guardado_next;
      r_cnt      <= w_cnt_next;
    end
  end

  always_comb begin
    w_estado_next   = r_estado;
    w_guardado_next = r_guardado;
    w_cnt_next      = r_cnt;
    w_choque        = 1'b0;
    w_esq           = 1'b0;
    w_recarga       = 1'b0;
    w_limpiar       = 1'b0;
    case (r_estado)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (w_en_juego) begin
          w_recarga     = 1'b1;
          w_estado_next = ST_ESPERA;
        end else begin
          w_limpiar = 1'b1;
        end
      end
      ST_ESPERA, ST_VENTANA: begin
        if (w_pausa) begin
          w_guardado_next = r_estado;
          w_estado_next   = ST_PAUSA;
        end else if (!w_en_juego) begin
          w_estado_next = ST_IDLE;
          w_limpiar     = 1'b1;
          w_cnt_next    = '0;
        end else if (r_estado == ST_ESPERA) begin
          if (w_llegada) begin
            w_cnt_next    = VENTANA - 24'd1;
            w_estado_next = ST_VENTANA;
          end
        end else if (w_llegada) begin
          // A newcomer closes the open window and immediately starts its own.
          w_esq      = w_ok;
          w_choque   = !w_ok;
          w_cnt_next = VENTANA - 24'd1;
        end else if (w_ok) begin
          w_esq         = 1'b1;
          w_cnt_next    = '0;
          w_estado_next = ST_ESPERA;
        end else if (r_cnt == 24'd0) begin
          w_choque      = 1'b1;
          w_estado_next = ST_ESPERA;
        end else begin
          w_cnt_next = r_cnt - 24'd1;
        end
      end
      ST_PAUSA: begin
        if (w_en_juego) begin
          w_estado_next = r_guardado;
        end else if (!w_pausa) begin
          w_estado_next = ST_IDLE;
          w_limpiar     = 1'b1;
          w_cnt_next    = '0;
        end
      end
      default: begin
        w_estado_next = ST_IDLE;
      end
    endcase
  end

  contador_bcd2 u_puntaje (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_recarga),
    .i_inc       (w_esq),
    .o_valor     (w_puntaje),
    .o_siguiente (w_puntaje_sig)
  );

  assign w_vidas_dec = (r_vidas == 2'd0) ? 2'd0 : r_vidas - 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vidas  <= VIDAS_INI;
      r_choque <= 1'b0;
      r_esq    <= 1'b0;
      r_gano   <= 1'b0;
      r_perdio <= 1'b0;
    end else begin
      if (w_recarga) begin
        r_vidas <= VIDAS_INI;
      end else if (w_choque) begin
        r_vidas <= w_vidas_dec;
      end
      r_choque <= w_choque;
      r_esq    <= w_esq;
      r_gano   <= w_esq && (w_puntaje_sig == META_BCD);
      r_perdio <= w_choque && (w_vidas_dec == 2'd0);
    end
  end

  assign bus.choque    = r_choque;
  assign bus.esquivado = r_esq;
  assign bus.gano      = r_gano;
  assign bus.perdio    = r_perdio;
  assign bus.vidas     = r_vidas;
  assign bus.puntaje   = w_puntaje;

endmodule

// File: tb/tb_colision_puntaje.sv
// Directed bench for colision_puntaje: verdict pulses are checked against a
// scoreboard queue filled when the matching stimulus is driven.
module tb_colision_puntaje;
  import heroe_pkg::*;

  localparam logic [23:0] VENT = 24'd8;
  localparam int          TICK = 32;
  localparam int          RAPIDO = 6;
  localparam logic [6:0]  SEG = 7'h3F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  colision_puntaje_if bus();

  colision_puntaje #(.VENTANA(VENT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ultimo_pulso = 0;
  int t_lleg = 0;

  logic [20:0] disp;
  logic [1:0]  m_vidas;
  logic [7:0]  m_punt;
  logic [13:0] esperados[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] bcd_inc(input logic [7:0] x);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = x[7:4];
    lo = x[3:0];
    if (x == 8'h99) return 8'h99;
    if (lo == 4'd9) return {hi + 4'd1, 4'd0};
    return {hi, lo + 4'd1};
  endfunction

  // Pulse monitor: every verdict pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [13:0] obs;
    logic [13:0] req;
    obs = {bus.choque, bus.esquivado, bus.gano, bus.perdio, bus.vidas, bus.puntaje};
    if (bus.choque || bus.esquivado || bus.gano || bus.perdio) begin
      ultimo_pulso = cyc;
      checks++;
      if (esperados.size() == 0) begin
        assert (esperados.size() != 0) else begin
          failures++;
          $error("FAIL pulso_inesperado obs=%h req=none cyc=%0d", obs, cyc);
        end
      end else begin
        req = esperados.pop_front();
        assert (obs === req) else begin
          failures++;
          $error("FAIL veredicto obs=%h req=%h cyc=%0d", obs, req, cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic comprobar(input string tag, input int obs, input int req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s obs=%0h req=%0h", tag, obs, req);
    end
  endtask

  task automatic desplazar(input logic spawn, input logic tipo);
    disp = {(spawn ? SEG : 7'h00), disp[20:7]};
    bus.display_obs = disp;
    if (spawn) bus.tipo_obs = {3'b000, tipo};
  endtask

  task automatic llegar(input logic tipo, input logic cambia, input int espacio);
    desplazar(1'b1, tipo);
    tick(espacio);
    desplazar(1'b0, 1'b0);
    if (cambia) bus.tipo_obs = {3'b000, ~tipo};
    tick(espacio);
    desplazar(1'b0, 1'b0);
    t_lleg = cyc;
  endtask

  task automatic espera_esq();
    m_punt = bcd_inc(m_punt);
    esperados.push_back({1'b0, 1'b1, (m_punt == 8'h20), 1'b0, m_vidas, m_punt});
  endtask

  task automatic espera_choque();
    m_vidas = (m_vidas == 2'd0) ? 2'd0 : m_vidas - 2'd1;
    esperados.push_back({1'b1, 1'b0, 1'b0, (m_vidas == 2'd0), m_vidas, m_punt});
  endtask

  task automatic drenar(input string tag);
    int n;
    n = 0;
    while (esperados.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    comprobar({tag, "_pendientes"}, esperados.size(), 0);
    esperados.delete();
  endtask

  task automatic estado(input string tag);
    comprobar({tag, "_vidas"}, int'(bus.vidas), int'(m_vidas));
    comprobar({tag, "_puntaje"}, int'(bus.puntaje), int'(m_punt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d req=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.presente    = OFF;
    bus.display_obs = '0;
    bus.tipo_obs    = '0;
    bus.accion      = ACC_SUELO;
    disp            = '0;
    m_vidas         = 2'd3;
    m_punt          = 8'h00;

    tick(3);
    comprobar("reset_pulsos", int'({bus.choque, bus.esquivado, bus.gano, bus.perdio}), 0);
    estado("reset");

    // Reset while a window is open and the jump action is held.
    rst_n = 1'b1;
    tick(2);
    bus.presente = CH;
    tick(4);
    bus.presente = GAME;
    tick(4);
    llegar(1'b0, 1'b0, TICK);
    tick(3);
    rst_n = 1'b0;
    bus.accion = ACC_SALTO;
    tick(1);
    comprobar("reset_vent_pulsos", int'({bus.choque, bus.esquivado, bus.gano, bus.perdio}), 0);
    estado("reset_vent");
    tick(2);
    rst_n = 1'b1;
    tick(20);
    bus.accion = ACC_SUELO;
    desplazar(1'b0, 1'b0);
    tick(TICK);
    estado("post_reset");

    // Jump on window cycle 3 clears a type-0 obstacle.
    llegar(1'b0, 1'b0, TICK);
    tick(4);
    espera_esq();
    bus.accion = ACC_SALTO;
    tick(1);
    bus.accion = ACC_SUELO;
    drenar("esq");
    comprobar("esq_latencia", ultimo_pulso - t_lleg, 5);
    desplazar(1'b0, 1'b0);
    tick(TICK);

    // Wrong action held through the whole window of a type-1 obstacle.
    llegar(1'b1, 1'b0, TICK);
    bus.accion = ACC_SALTO;
    espera_choque();
    drenar("choque");
    comprobar("choque_latencia", ultimo_pulso - t_lleg, 10);
    bus.accion = ACC_SUELO;
    desplazar(1'b0, 1'b0);
    tick(TICK);
    estado("choque");

    // Generator moves on to type 1 while the type-0 obstacle is in digit 1.
    llegar(1'b0, 1'b1, TICK);
    tick(2);
    espera_esq();
    bus.accion = ACC_SALTO;
    tick(1);
    bus.accion = ACC_SUELO;
    drenar("sombra_tipo");
    desplazar(1'b0, 1'b0);
    bus.tipo_obs = 4'h0;
    tick(TICK);

    // Pause during window cycle 4; the window must resume where it stopped.
    llegar(1'b1, 1'b0, TICK);
    espera_choque();
    tick(4);
    bus.presente = PA;
    tick(100);
    bus.presente = GAME;
    drenar("pausa");
    comprobar("pausa_latencia", ultimo_pulso - t_lleg, 111);
    desplazar(1'b0, 1'b0);
    tick(TICK);
    estado("pausa");

    // Last life lost: perdio coincides with choque.
    llegar(1'b1, 1'b0, TICK);
    espera_choque();
    drenar("perdio");
    desplazar(1'b0, 1'b0);
    tick(TICK);
    estado("perdio");

    // Leaving GAME mid-window aborts silently and holds the counters.
    llegar(1'b1, 1'b0, TICK);
    tick(3);
    bus.presente = WL;
    tick(20);
    estado("abort");
    desplazar(1'b0, 1'b0);
    tick(4);
    bus.presente = GAME;
    m_vidas = 2'd3;
    m_punt  = 8'h00;
    tick(4);
    estado("nuevo_juego");

    // 100 consecutive clears: gano at 20, saturation at 99.
    for (int i = 0; i < 100; i++) begin
      llegar(1'(i % 2), 1'b0, RAPIDO);
      tick(2);
      espera_esq();
      bus.accion = (i % 2 == 1) ? ACC_AGACHE : ACC_SALTO;
      tick(1);
      bus.accion = ACC_SUELO;
      desplazar(1'b0, 1'b0);
      drenar("racha");
      tick(RAPIDO);
      if (i == 19) estado("meta");
    end
    estado("saturado");

    // A second obstacle lands while the first window is still open.
    desplazar(1'b1, 1'b1);
    tick(TICK);
    desplazar(1'b1, 1'b1);
    tick(TICK);
    desplazar(1'b0, 1'b0);
    tick(4);
    espera_choque();
    espera_choque();
    desplazar(1'b0, 1'b0);
    drenar("doble");
    desplazar(1'b0, 1'b0);
    tick(TICK);
    estado("doble");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
